// File: rtl/ex_mem_stage.sv
// ============================================================================
// ex_mem_stage: EX/MEM pipeline register with NZCV flag register and branch resolve
// Revision: 1.0
// ============================================================================
`default_nettype none

module ex_mem_stage #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] PCBranch_E,
  input  logic [N-1:0] aluResult_E,
  input  logic [N-1:0] writeData_E,
  input  logic         zero_E,
  input  logic         negative_E,
  input  logic         carry_E,
  input  logic         overflow_E,
  input  logic         write_flags_E,
  input  logic         Branch_E,
  input  logic         CondBranch_E,
  input  logic         memRead_E,
  input  logic         memWrite_E,
  input  logic         regWrite_E,
  input  logic         memtoReg_E,
  input  logic [3:0]   cond_E,
  input  logic [4:0]   writeReg_E,
  input  logic         stall,
  input  logic         flush,
  output logic [N-1:0] PCBranch_M,
  output logic [N-1:0] aluResult_M,
  output logic [N-1:0] writeData_M,
  output logic         zero_M,
  output logic         memRead_M,
  output logic         memWrite_M,
  output logic         regWrite_M,
  output logic         memtoReg_M,
  output logic [4:0]   writeReg_M,
  output logic [3:0]   flags_M,
  output logic         PCSrc_M
);

  logic [N-1:0] pcbranch_q, pcbranch_d;
  logic [N-1:0] aluresult_q, aluresult_d;
  logic [N-1:0] writedata_q, writedata_d;
  logic         zero_q, zero_d;
  logic         branch_q, branch_d;
  logic         condbranch_q, condbranch_d;
  logic         memread_q, memread_d;
  logic         memwrite_q, memwrite_d;
  logic         regwrite_q, regwrite_d;
  logic         memtoreg_q, memtoreg_d;
  logic [4:0]   writereg_q, writereg_d;
  logic [3:0]   cond_q, cond_d;
  logic [3:0]   flags_q, flags_d;

  logic w_bubble;
  logic w_cond_true;
  logic w_pcsrc;

  // flags layout is {N, Z, C, V}
  function automatic logic cond_true(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    n  = f[3];
    z  = f[2];
    cy = f[1];
    v  = f[0];
    case (c)
      4'b0000: cond_true = z;
      4'b0001: cond_true = !z;
      4'b0010: cond_true = cy;
      4'b0011: cond_true = !cy;
      4'b0100: cond_true = n;
      4'b0101: cond_true = !n;
      4'b0110: cond_true = v;
      4'b0111: cond_true = !v;
      4'b1000: cond_true = cy & !z;
      4'b1001: cond_true = !cy | z;
      4'b1010: cond_true = (n == v);
      4'b1011: cond_true = (n != v);
      4'b1100: cond_true = !z & (n == v);
      4'b1101: cond_true = z | (n != v);
      default: cond_true = 1'b1;
    endcase
  endfunction

  assign w_cond_true = cond_true(cond_q, flags_q);
  assign w_pcsrc     = (branch_q & zero_q) | (condbranch_q & w_cond_true);

  // A taken branch squashes the wrong-path instruction currently in EX
  assign w_bubble = flush | w_pcsrc;

  always_comb begin
    pcbranch_d   = pcbranch_q;
    aluresult_d  = aluresult_q;
    writedata_d  = writedata_q;
    zero_d       = zero_q;
    branch_d     = branch_q;
    condbranch_d = condbranch_q;
    memread_d    = memread_q;
    memwrite_d   = memwrite_q;
    regwrite_d   = regwrite_q;
    memtoreg_d   = memtoreg_q;
    writereg_d   = writereg_q;
    cond_d       = cond_q;
    flags_d      = flags_q;
    if (!stall) begin
      pcbranch_d  = PCBranch_E;
      aluresult_d = aluResult_E;
      writedata_d = writeData_E;
      writereg_d  = writeReg_E;
      cond_d      = cond_E;
      if (w_bubble) begin
        zero_d       = 1'b0;
        branch_d     = 1'b0;
        condbranch_d = 1'b0;
        memread_d    = 1'b0;
        memwrite_d   = 1'b0;
        regwrite_d   = 1'b0;
        memtoreg_d   = 1'b0;
      end else begin
        zero_d       = zero_E;
        branch_d     = Branch_E;
        condbranch_d = CondBranch_E;
        memread_d    = memRead_E;
        memwrite_d   = memWrite_E;
        regwrite_d   = regWrite_E;
        memtoreg_d   = memtoReg_E;
        if (write_flags_E) begin
          flags_d = {negative_E, zero_E, carry_E, overflow_E};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pcbranch_q   <= '0;
      aluresult_q  <= '0;
      writedata_q  <= '0;
      zero_q       <= 1'b0;
      branch_q     <= 1'b0;
      condbranch_q <= 1'b0;
      memread_q    <= 1'b0;
      memwrite_q   <= 1'b0;
      regwrite_q   <= 1'b0;
      memtoreg_q   <= 1'b0;
      writereg_q   <= '0;
      cond_q       <= '0;
      flags_q      <= '0;
    end else begin
      pcbranch_q   <= pcbranch_d;
      aluresult_q  <= aluresult_d;
      writedata_q  <= writedata_d;
      zero_q       <= zero_d;
      branch_q     <= branch_d;
      condbranch_q <= condbranch_d;
      memread_q    <= memread_d;
      memwrite_q   <= memwrite_d;
      regwrite_q   <= regwrite_d;
      memtoreg_q   <= memtoreg_d;
      writereg_q   <= writereg_d;
      cond_q       <= cond_d;
      flags_q      <= flags_d;
    end
  end

  assign PCBranch_M  = pcbranch_q;
  assign aluResult_M = aluresult_q;
  assign writeData_M = writedata_q;
  assign zero_M      = zero_q;
  assign memRead_M   = memread_q;
  assign memWrite_M  = memwrite_q;
  assign regWrite_M  = regwrite_q;
  assign memtoReg_M  = memtoreg_q;
  assign writeReg_M  = writereg_q;
  assign flags_M     = flags_q;
  assign PCSrc_M     = w_pcsrc;

endmodule

`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
// ============================================================================
// tb_ex_mem_stage: directed vectors checked against a behavioural EX/MEM model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ex_mem_stage;
  localparam int N = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] PCBranch_E, aluResult_E, writeData_E;
  logic         zero_E, negative_E, carry_E, overflow_E, write_flags_E;
  logic         Branch_E, CondBranch_E, memRead_E, memWrite_E, regWrite_E, memtoReg_E;
  logic [3:0]   cond_E;
  logic [4:0]   writeReg_E;
  logic         stall, flush;
  logic [N-1:0] PCBranch_M, aluResult_M, writeData_M;
  logic         zero_M, memRead_M, memWrite_M, regWrite_M, memtoReg_M;
  logic [4:0]   writeReg_M;
  logic [3:0]   flags_M;
  logic         PCSrc_M;

  int checks = 0;
  int errors = 0;

  ex_mem_stage #(.N(N)) dut (
    .clk(clk), .reset(reset),
    .PCBranch_E(PCBranch_E), .aluResult_E(aluResult_E), .writeData_E(writeData_E),
    .zero_E(zero_E), .negative_E(negative_E), .carry_E(carry_E), .overflow_E(overflow_E),
    .write_flags_E(write_flags_E), .Branch_E(Branch_E), .CondBranch_E(CondBranch_E),
    .memRead_E(memRead_E), .memWrite_E(memWrite_E), .regWrite_E(regWrite_E),
    .memtoReg_E(memtoReg_E), .cond_E(cond_E), .writeReg_E(writeReg_E),
    .stall(stall), .flush(flush),
    .PCBranch_M(PCBranch_M), .aluResult_M(aluResult_M), .writeData_M(writeData_M),
    .zero_M(zero_M), .memRead_M(memRead_M), .memWrite_M(memWrite_M),
    .regWrite_M(regWrite_M), .memtoReg_M(memtoReg_M), .writeReg_M(writeReg_M),
    .flags_M(flags_M), .PCSrc_M(PCSrc_M)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Condition codes come in pairs: odd codes invert the even base test, 111x always true.
  function automatic bit m_cond(input bit [3:0] c, input bit [3:0] f);
    bit n, z, cy, v, base;
    {n, z, cy, v} = f;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return (c[3:1] == 3'd7) ? 1'b1 : (base ^ c[0]);
  endfunction

  bit [N-1:0] m_pcb, m_alu, m_wd;
  bit         m_zero, m_br, m_cbr, m_mr, m_mw, m_rw, m_m2r;
  bit [4:0]   m_wr;
  bit [3:0]   m_cond_r, m_flags;
  bit         started = 1'b0;

  function automatic bit m_pcsrc();
    return (m_br && m_zero) || (m_cbr && m_cond(m_cond_r, m_flags));
  endfunction

  always @(posedge clk) begin
    bit taken;
    taken = m_pcsrc();
    if (reset) begin
      {m_pcb, m_alu, m_wd} = '0;
      {m_zero, m_br, m_cbr, m_mr, m_mw, m_rw, m_m2r} = '0;
      m_wr = '0; m_cond_r = '0; m_flags = '0;
    end else if (!stall) begin
      m_pcb = PCBranch_E; m_alu = aluResult_E; m_wd = writeData_E;
      m_wr = writeReg_E; m_cond_r = cond_E;
      if (flush || taken) begin
        {m_zero, m_br, m_cbr, m_mr, m_mw, m_rw, m_m2r} = '0;
      end else begin
        {m_zero, m_br, m_cbr, m_mr, m_mw, m_rw, m_m2r} =
          {zero_E, Branch_E, CondBranch_E, memRead_E, memWrite_E, regWrite_E, memtoReg_E};
        if (write_flags_E) m_flags = {negative_E, zero_E, carry_E, overflow_E};
      end
    end
    started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      chk("PCBranch_M",  PCBranch_M,  m_pcb);
      chk("aluResult_M", aluResult_M, m_alu);
      chk("writeData_M", writeData_M, m_wd);
      chk("ctrl_M", {59'd0, zero_M, memRead_M, memWrite_M, regWrite_M, memtoReg_M},
          {59'd0, m_zero, m_mr, m_mw, m_rw, m_m2r});
      chk("writeReg_M",  {59'd0, writeReg_M}, {59'd0, m_wr});
      chk("flags_M",     {60'd0, flags_M},    {60'd0, m_flags});
      chk("PCSrc_M",     {63'd0, PCSrc_M},    {63'd0, m_pcsrc()});
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    PCBranch_E = '0; aluResult_E = '0; writeData_E = '0;
    {zero_E, negative_E, carry_E, overflow_E, write_flags_E} = '0;
    {Branch_E, CondBranch_E, memRead_E, memWrite_E, regWrite_E, memtoReg_E} = '0;
    cond_E = '0; writeReg_E = '0; stall = 1'b0; flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic setter(input bit [3:0] f);
    idle();
    write_flags_E = 1'b1;
    {negative_E, zero_E, carry_E, overflow_E} = f;
    tick();
  endtask

  task automatic bcond(input bit [3:0] c);
    idle();
    CondBranch_E = 1'b1; cond_E = c;
    tick();
  endtask

  logic [N-1:0] held_alu;
  logic [3:0]   fpat [6];

  initial begin
    idle();
    reset = 1'b1;
    tick(); tick();
    chk("rst_alu",   aluResult_M, 64'h0);
    chk("rst_flags", {60'd0, flags_M}, 64'h0);
    chk("rst_pcsrc", {63'd0, PCSrc_M}, 64'h0);
    reset = 1'b0;

    // plain load
    idle(); aluResult_E = 64'h1234; regWrite_E = 1'b1; writeReg_E = 5'd5;
    PCBranch_E = 64'hDEAD_BEEF_0000_1000; writeData_E = 64'h55AA;
    tick();
    chk("load_alu",  aluResult_M, 64'h1234);
    chk("load_rw",   {63'd0, regWrite_M}, 64'h1);
    chk("load_wr",   {59'd0, writeReg_M}, 64'h5);

    // SUBS then B.LT (taken), then B.GE (not taken)
    setter(4'b1000);
    chk("subs_flags", {60'd0, flags_M}, 64'h8);
    bcond(4'b1011);
    chk("blt_taken", {63'd0, PCSrc_M}, 64'h1);
    idle(); tick();
    chk("blt_squash", {63'd0, PCSrc_M}, 64'h0);
    bcond(4'b1010);
    chk("bge_not_taken", {63'd0, PCSrc_M}, 64'h0);

    // CBZ taken squashes the following flag-setting instruction
    idle(); Branch_E = 1'b1; zero_E = 1'b1; tick();
    chk("cbz_taken", {63'd0, PCSrc_M}, 64'h1);
    idle(); regWrite_E = 1'b1; write_flags_E = 1'b1;
    {negative_E, zero_E, carry_E, overflow_E} = 4'b1111; tick();
    chk("squash_rw",    {63'd0, regWrite_M}, 64'h0);
    chk("squash_flags", {60'd0, flags_M}, 64'h8);
    chk("squash_pcsrc", {63'd0, PCSrc_M}, 64'h0);

    // stall while a taken branch sits in M
    idle(); Branch_E = 1'b1; zero_E = 1'b1; aluResult_E = 64'h77; tick();
    held_alu = aluResult_M;
    for (int i = 0; i < 3; i++) begin
      idle(); stall = 1'b1;
      aluResult_E = {$urandom, $urandom}; regWrite_E = 1'b1; write_flags_E = 1'b1;
      {negative_E, zero_E, carry_E, overflow_E} = 4'($urandom);
      tick();
      chk("stall_pcsrc", {63'd0, PCSrc_M}, 64'h1);
      chk("stall_alu",   aluResult_M, held_alu);
      chk("stall_flags", {60'd0, flags_M}, 64'h8);
    end
    idle(); memWrite_E = 1'b1; tick();
    chk("post_stall_bubble", {63'd0, memWrite_M}, 64'h0);

    // flush vs stall
    idle(); memWrite_E = 1'b1; aluResult_E = 64'hA0; tick();
    chk("mw_load", {63'd0, memWrite_M}, 64'h1);
    idle(); flush = 1'b1; stall = 1'b1; memWrite_E = 1'b0; aluResult_E = 64'hB0; tick();
    chk("flush_stall_hold", {63'd0, memWrite_M}, 64'h1);
    chk("flush_stall_alu",  aluResult_M, 64'hA0);
    idle(); flush = 1'b1; memWrite_E = 1'b1; aluResult_E = 64'hC0; tick();
    chk("flush_mw",  {63'd0, memWrite_M}, 64'h0);
    chk("flush_alu", aluResult_M, 64'hC0);

    // reset in the middle of operation, with stall also asserted
    setter(4'b1111);
    chk("ffff_flags", {60'd0, flags_M}, 64'hF);
    idle(); Branch_E = 1'b1; aluResult_E = 64'h99; tick();
    idle(); reset = 1'b1; stall = 1'b1; aluResult_E = 64'h42; tick();
    chk("midrst_flags", {60'd0, flags_M}, 64'h0);
    chk("midrst_alu",   aluResult_M, 64'h0);
    chk("midrst_pcsrc", {63'd0, PCSrc_M}, 64'h0);
    reset = 1'b0; idle(); aluResult_E = 64'h31; memRead_E = 1'b1; tick();
    chk("postrst_load", aluResult_M, 64'h31);
    chk("postrst_mr",   {63'd0, memRead_M}, 64'h1);

    // condition sweep: every code against several flag patterns
    fpat[0] = 4'b0000; fpat[1] = 4'b0100; fpat[2] = 4'b0010;
    fpat[3] = 4'b1001; fpat[4] = 4'b1000; fpat[5] = 4'b0110;
    for (int p = 0; p < 6; p++) begin
      for (int c = 0; c < 16; c++) begin
        setter(fpat[p]);
        bcond(4'(c));
        idle(); tick();
      end
    end
    // hand-pinned sweep points (flags {N,Z,C,V})
    setter(4'b0010); bcond(4'b1000);
    chk("bhi_c_noz", {63'd0, PCSrc_M}, 64'h1);
    idle(); tick();
    setter(4'b0110); bcond(4'b1000);
    chk("bhi_c_z", {63'd0, PCSrc_M}, 64'h0);
    idle(); tick();
    setter(4'b1000); bcond(4'b1101);
    chk("ble_nnev", {63'd0, PCSrc_M}, 64'h1);
    idle(); tick();
    setter(4'b0000); bcond(4'b1111);
    chk("nv_always", {63'd0, PCSrc_M}, 64'h1);
    idle(); tick();

    // data-path patterns
    for (int k = 0; k < 8; k++) begin
      idle();
      PCBranch_E = {$urandom, $urandom}; aluResult_E = {$urandom, $urandom};
      writeData_E = {$urandom, $urandom}; writeReg_E = 5'($urandom);
      {memRead_E, memWrite_E, regWrite_E, memtoReg_E} = 4'($urandom);
      flush = ($urandom_range(0, 3) == 0);
      tick();
    end

    idle(); tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
